// File: rtl/jtag_shift_engine_pkg.sv
// Shared types for the JTAG shift engine: opcodes, FSM states, defaults.
package jtag_shift_pkg;

    localparam int DEF_RESET_CLKS = 5;

    typedef enum logic [2:0] {
        OP_RESET     = 3'd0,
        OP_TMS_SEQ   = 3'd1,
        OP_SCAN      = 3'd2,
        OP_SCAN_EXIT = 3'd3,
        OP_RUNTEST   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOW,
        ST_HIGH,
        ST_PUSH,
        ST_DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/jtag_shift_engine_if.sv
// Host-side command / tx / rx streams of the JTAG shift engine.
interface jtag_shift_engine_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_nbits;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_last;

    modport master (
        output cmd_valid, cmd_op, cmd_nbits, tx_valid, tx_data, rx_ready,
        input  cmd_ready, tx_ready, rx_valid, rx_data, rx_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_nbits, tx_valid, tx_data, rx_ready,
        output cmd_ready, tx_ready, rx_valid, rx_data, rx_last
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: each half-period lasts div+1 clk cycles; held low while disabled.
module jtag_tck_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tck,
    output logic             rise,
    output logic             fall
);
    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // Strobes mark the last cycle of a half-period; tck toggles on the following edge.
    assign wrap = en && (cnt == div);
    assign rise = wrap && !tck;
    assign fall = wrap && tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: executes reset / TMS / scan / run-idle opcodes, streaming LSB-first words.
// Define JTAG_SHIFT_ENGINE_TRST_EN to add the trst_n output.
module jtag_shift_engine
    import jtag_shift_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 16,
    parameter int DIV_W      = 8,
    parameter int RESET_CLKS = DEF_RESET_CLKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   clk_div,
    jtag_shift_engine_if.slave bus,
    output logic               busy,
    output logic               err,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    ,
    output logic               trst_n
`endif
);
    localparam int IDX_W = $clog2(DATA_W);

    state_e            state, state_nxt;
    op_e               op_q;
    logic [LEN_W-1:0]  bits_left;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] tx_word, rx_word;
    logic [DIV_W-1:0]  div_q;
    logic              tck_en, rise, fall;
    logic              accept, active, is_scan, uses_tx, last_bit, word_end, cur_bit;

    assign accept   = bus.cmd_valid && (state == ST_IDLE);
    assign active   = (state == ST_LOW) || (state == ST_HIGH);
    assign is_scan  = (op_q == OP_SCAN) || (op_q == OP_SCAN_EXIT);
    assign uses_tx  = is_scan || (op_q == OP_TMS_SEQ);
    assign last_bit = (bits_left == LEN_W'(1));
    assign word_end = (widx == IDX_W'(DATA_W - 1));
    assign cur_bit  = tx_word[widx];
    assign tck_en   = active;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.tx_ready  = (state == ST_FETCH) && bus.tx_valid;
    assign bus.rx_valid  = (state == ST_PUSH);
    assign bus.rx_last   = (state == ST_PUSH) && (bits_left == '0);
    assign bus.rx_data   = rx_word;
    assign busy          = (state != ST_IDLE);

    jtag_tck_gen #(.DIV_W(DIV_W)) u_tck (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tck_en),
        .div  (div_q),
        .tck  (tck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tms       = 1'b0;
        tdi       = 1'b0;
        case (state)
            ST_IDLE: if (bus.cmd_valid) begin
                if (!op_legal(bus.cmd_op))         state_nxt = ST_DONE;
                else if (bus.cmd_op == OP_RESET)   state_nxt = ST_LOW;
                else if (bus.cmd_nbits == '0)      state_nxt = ST_DONE;
                else if (bus.cmd_op == OP_RUNTEST) state_nxt = ST_LOW;
                else                               state_nxt = ST_FETCH;
            end
            ST_FETCH: if (bus.tx_valid) state_nxt = ST_LOW;
            ST_LOW:   if (rise) state_nxt = ST_HIGH;
            ST_HIGH: if (fall) begin
                if (last_bit)                 state_nxt = is_scan ? ST_PUSH : ST_DONE;
                else if (uses_tx && word_end) state_nxt = is_scan ? ST_PUSH : ST_FETCH;
                else                          state_nxt = ST_LOW;
            end
            ST_PUSH: if (bus.rx_ready) state_nxt = (bits_left == '0) ? ST_DONE : ST_FETCH;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Pin values are held across both TCK phases of a bit.
        if (active) begin
            case (op_q)
                OP_RESET:     tms = !last_bit;
                OP_TMS_SEQ:   tms = cur_bit;
                OP_SCAN:      tdi = cur_bit;
                OP_SCAN_EXIT: begin tdi = cur_bit; tms = last_bit; end
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_RESET;
            bits_left <= '0;
            widx      <= '0;
            tx_word   <= '0;
            rx_word   <= '0;
            div_q     <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && !op_legal(bus.cmd_op);
            if (accept) begin
                op_q      <= op_e'(bus.cmd_op);
                div_q     <= clk_div;
                widx      <= '0;
                rx_word   <= '0;
                bits_left <= (bus.cmd_op == OP_RESET) ? LEN_W'(RESET_CLKS + 1) : bus.cmd_nbits;
            end
            if (state == ST_FETCH && bus.tx_valid) tx_word <= bus.tx_data;
            if (state == ST_LOW && rise && is_scan) rx_word[widx] <= tdo;
            if (state == ST_HIGH && fall) begin
                if (bits_left != '0) bits_left <= bits_left - LEN_W'(1);
                widx <= widx + IDX_W'(1);
            end
            if (state == ST_PUSH && bus.rx_ready) rx_word <= '0;
        end
    end

`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    logic trst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trst_q <= 1'b0;
        else        trst_q <= 1'b1;
    end

    assign trst_n = trst_q && !(active && op_q == OP_RESET && !last_bit);
`endif

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: looped-back TAP, scoreboard of expected rx words.
module tb_jtag_shift_engine;
    import jtag_shift_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    localparam logic [31:0] RST_V = 32'h2000;

    logic       clk, rst_n, busy, err, tck, tms, tdi, tdo;
    logic [7:0] clk_div;
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    logic       trst_n;
`endif

    jtag_shift_engine_if #(.DATA_W(8), .LEN_W(16)) bus ();

    jtag_shift_engine #(.DATA_W(8), .LEN_W(16), .DIV_W(8), .RESET_CLKS(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_div(clk_div),
        .bus    (bus),
        .busy   (busy),
        .err    (err),
        .tck    (tck),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo)
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
        ,
        .trst_n (trst_n)
`endif
    );

    // TAP model: bypass-style loopback, TDO mirrors TDI.
    assign tdo = tdi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, rises = 0, tx_acks = 0, errs = 0, stall_hi = 0;
    int         last_fall_cyc = 0, busy_fall_cyc = 0;
    logic       tck_q = 1'b0, busy_q = 1'b0, tx_fire = 1'b0, stalled = 1'b0;
    logic [7:0] txq[$];
    exp_t       exp_q[$];
    bit         tms_log[$], tdi_log[$];
    int         rise_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return {15'd0, tck, tms, tdi, bus.cmd_ready, bus.tx_ready, bus.rx_valid,
                bus.rx_last, bus.rx_data, busy, err};
    endfunction

    function automatic logic [15:0] pat_of(input bit q[$], input int base, input int n);
        logic [15:0] p = '0;
        for (int i = 0; i < n; i++) if (base + i < q.size()) p[i] = q[base + i];
        return p;
    endfunction

    // One clk cycle: observe at negedge, update tx stream just after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tck && !tck_q) begin
            rises++;
            tms_log.push_back(tms);
            tdi_log.push_back(tdi);
            rise_cyc.push_back(cyc);
        end
        if (!tck && tck_q) last_fall_cyc = cyc;
        tck_q = tck;
        if (!busy && busy_q) busy_fall_cyc = cyc;
        busy_q  = busy;
        tx_fire = bus.tx_valid && bus.tx_ready;
        if (tx_fire) tx_acks++;
        if (err) errs++;
        if (stalled && tck) stall_hi++;
        if (bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
                chk("rx_last", {31'd0, bus.rx_last}, {31'd0, e.last});
            end
        end
        @(posedge clk);
        #1;
        if (tx_fire && txq.size() != 0) void'(txq.pop_front());
        bus.tx_valid = (txq.size() != 0);
        bus.tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
    endtask

    // Queue tx words for an nbits transfer; for scans also the looped-back rx words.
    task automatic load(input int nbits, input logic [15:0] bits, input bit scan);
        int         nw;
        logic [7:0] d;
        exp_t       e;
        nw = (nbits + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            d = bits[8*i +: 8];
            txq.push_back(d);
            if (scan) begin
                for (int b = nbits - 8*i; b < 8; b++) if (b >= 0) d[b] = 1'b0;
                e.data = d;
                e.last = (i == nw - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input int nbits, input logic [7:0] div);
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin tick(); n++; end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_nbits = 16'(nbits);
        clk_div       = div;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || !bus.cmd_ready) && n < 3000) begin tick(); n++; end
        chk({tag, "_done"}, {31'd0, n < 3000}, 32'd1);
        tick();
    endtask

    initial begin
        int r0, a0, e0, b0, n;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_nbits = '0;
        bus.tx_valid = 1'b0;  bus.tx_data = '0; bus.rx_ready = 1'b1;
        clk_div = '0;
        repeat (2) tick();
        chk("reset_outputs", outv(), RST_V);
        rst_n = 1'b1;
        repeat (2) tick();

        // OP_RESET at full speed
        b0 = tms_log.size(); r0 = rises;
        issue(OP_RESET, 0, 8'd0);
        wait_idle("op_reset");
        chk("reset_tck_pulses", rises - r0, 32'd6);
        chk("reset_tms_pattern", {16'd0, pat_of(tms_log, b0, 6)}, 32'h1F);
        chk("reset_tck_period", rise_cyc[b0 + 1] - rise_cyc[b0], 32'd2);
        chk("reset_busy_after_fall", busy_fall_cyc - last_fall_cyc, 32'd1);

        // 12-bit scan across two words
        b0 = tms_log.size(); r0 = rises;
        load(12, 16'h0FA5, 1'b1);
        issue(OP_SCAN, 12, 8'd0);
        wait_idle("scan12");
        chk("scan12_tck_pulses", rises - r0, 32'd12);
        chk("scan12_tms_low", {16'd0, pat_of(tms_log, b0, 12)}, 32'd0);

        // Scan with exit on final bit, slower TCK
        b0 = tms_log.size(); r0 = rises;
        load(3, 16'h0005, 1'b1);
        issue(OP_SCAN_EXIT, 3, 8'd2);
        wait_idle("scan_exit");
        chk("exit_tms_pattern", {16'd0, pat_of(tms_log, b0, 3)}, 32'h4);
        chk("exit_tck_pulses", rises - r0, 32'd3);

        // 16-bit scan with rx backpressure on the first word
        r0 = rises;
        bus.rx_ready = 1'b0;
        load(16, 16'hC35A, 1'b1);
        issue(OP_SCAN, 16, 8'd1);
        n = 0;
        while (!bus.rx_valid && n < 2000) begin tick(); n++; end
        chk("stall_first_word", {31'd0, bus.rx_valid}, 32'd1);
        a0 = rises; stall_hi = 0; stalled = 1'b1;
        repeat (40) tick();
        stalled = 1'b0;
        chk("stall_no_tck_rise", rises - a0, 32'd0);
        chk("stall_tck_low", stall_hi, 32'd0);
        chk("stall_rx_held", {31'd0, bus.rx_valid}, 32'd1);
        bus.rx_ready = 1'b1;
        wait_idle("scan16");
        chk("scan16_tck_pulses", rises - r0, 32'd16);

        // Zero-length TMS sequence and an illegal opcode with a tx word pending
        r0 = rises; a0 = tx_acks; e0 = errs;
        txq.push_back(8'h0B);
        issue(OP_TMS_SEQ, 0, 8'd0);
        wait_idle("tms_zero");
        issue(3'd6, 4, 8'd0);
        wait_idle("illegal_op");
        chk("zero_no_tck", rises - r0, 32'd0);
        chk("zero_no_tx_ready", tx_acks - a0, 32'd0);
        chk("illegal_err_once", errs - e0, 32'd1);

        // The pending word now drives a real 5-bit TMS sequence
        b0 = tms_log.size();
        issue(OP_TMS_SEQ, 5, 8'd0);
        wait_idle("tms_seq5");
        chk("tms_seq_pattern", {16'd0, pat_of(tms_log, b0, 5)}, 32'h0B);
        chk("tms_seq_tdi_low", {16'd0, pat_of(tdi_log, b0, 5)}, 32'd0);
        chk("tms_seq_one_word", tx_acks - a0, 32'd1);

        // Reset in the middle of a long run-test
        r0 = rises;
        issue(OP_RUNTEST, 100, 8'd1);
        repeat (30) tick();
        chk("runtest_running", {31'd0, (rises - r0) > 0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midcmd_reset_outputs", outv(), RST_V);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        r0 = rises;
        load(8, 16'h003C, 1'b1);
        issue(OP_SCAN, 8, 8'd2);
        wait_idle("post_reset_scan");
        chk("post_reset_tck_pulses", rises - r0, 32'd8);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
